mux_derive: RTL

MUX_DERIVE -- requirements
Module: mux_derive

---
 rtl/mux_derive_pkg.sv | 21 ++
 rtl/pair_classifier.sv | 21 ++
 rtl/mux_derive.sv | 113 +++++++++++
 3 files changed

// File: rtl/mux_derive_pkg.sv
// Shared types for the mux_derive truth-table sweeper: FSM states and 8:1-mux data-input codes.
package mux_derive_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SAMPLE,
        S_ENCODE,
        S_DONE
    } state_t;

    typedef logic [1:0] code_t;

    localparam code_t CODE_ZERO  = 2'b00;
    localparam code_t CODE_ONE   = 2'b01;
    localparam code_t CODE_D     = 2'b10;
    localparam code_t CODE_NOT_D = 2'b11;

    localparam int unsigned NUM_PAIRS = 8;

endpackage

// File: rtl/pair_classifier.sv
// Classifies one truth-table pair (d=0, d=1) as the 8:1-mux data input that realises it.
// Purely combinational, no backpressure.
module pair_classifier
    import mux_derive_pkg::*;
(
    input  logic  i_t0,
    input  logic  i_t1,
    output code_t o_code
);

    always_comb begin
        o_code = CODE_ZERO;
        case ({i_t1, i_t0})
            2'b00:   o_code = CODE_ZERO;
            2'b11:   o_code = CODE_ONE;
            2'b10:   o_code = CODE_D;
            default: o_code = CODE_NOT_D;
        endcase
    end

endmodule

// File: rtl/mux_derive.sv
// Sweeps a 4-input function over all 16 inputs, captures its truth table and (with
// MUX_DERIVE_ENCODE_EN) derives the 8:1-mux data codes; done 34 cycles after start (33 without encode).
module mux_derive
    import mux_derive_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_y,
    output logic        o_a,
    output logic        o_b,
    output logic        o_c,
    output logic        o_d,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_valid,
    output logic [15:0] o_table,
    output logic [15:0] o_codes
);

`ifdef MUX_DERIVE_ENCODE_EN
    localparam bit ENCODE_EN = 1'b1;
`else
    localparam bit ENCODE_EN = 1'b0;
`endif

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_idx;
    logic [3:0]  w_idx_nxt;
    logic [3:0]  r_abcd;
    logic [3:0]  w_abcd_nxt;
    logic        r_valid;
    logic [15:0] r_table;
    logic [15:0] r_codes;
    logic [15:0] w_codes;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_APPLY;
                    w_idx_nxt   = 4'd0;
                end
            end
            S_APPLY:  w_state_nxt = S_SAMPLE;
            S_SAMPLE: begin
                if (r_idx == 4'hF) begin
                    w_state_nxt = ENCODE_EN ? S_ENCODE : S_DONE;
                end else begin
                    w_state_nxt = S_APPLY;
                    w_idx_nxt   = r_idx + 4'd1;
                end
            end
            S_ENCODE: w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Stimulus is registered from the next-state view so a,b,c,d change only on clock edges.
    always_comb begin
        w_abcd_nxt = 4'd0;
        if (w_state_nxt == S_APPLY || w_state_nxt == S_SAMPLE) begin
            w_abcd_nxt = w_idx_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_idx   <= 4'd0;
            r_abcd  <= 4'd0;
            r_valid <= 1'b0;
            r_table <= 16'd0;
            r_codes <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_abcd  <= w_abcd_nxt;
            if (r_state == S_IDLE && i_start) begin
                r_valid <= 1'b0;
            end
            if (r_state == S_DONE) begin
                r_valid <= 1'b1;
            end
            if (r_state == S_SAMPLE) begin
                r_table[r_idx] <= i_y;
            end
            if (r_state == S_ENCODE) begin
                r_codes <= w_codes;
            end
        end
    end

    for (genvar k = 0; k < NUM_PAIRS; k++) begin : g_pair
        pair_classifier u_pair_classifier (
            .i_t0   (r_table[2*k]),
            .i_t1   (r_table[2*k+1]),
            .o_code (w_codes[2*k +: 2])
        );
    end

    assign {o_a, o_b, o_c, o_d} = r_abcd;
    assign o_busy  = (r_state != S_IDLE);
    assign o_done  = (r_state == S_DONE);
    assign o_valid = r_valid;
    assign o_table = r_table;
    assign o_codes = ENCODE_EN ? r_codes : 16'd0;

endmodule
